// File: rtl/load_store_unit.sv
// load_store_unit -- memory-access stage of the RV32I core.
//
// Takes the ALU result as the effective address and runs one request/ack
// transaction on the data bus per accepted access.
//   - Loads return aligned, sign- or zero-extended data on wb_*.
//   - Stores drive byte strobes and lane-replicated data on mem_*.
//   - Illegal width codes, misaligned accesses (optional trap), bus errors and
//     bus timeouts are reported as one-cycle exceptions on exc_*.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW trap (cause 4/6) without a bus access
//   undefined : misaligned addresses are force-aligned and the access proceeds
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   lsu_valid/lsu_ready         request handshake from execute
//   lsu_is_store, lsu_funct3,
//   lsu_addr, lsu_wdata, lsu_rd request payload
//   mem_req/we/addr/wstrb/wdata data-bus request, held until mem_ack/mem_err
//   mem_rdata, mem_ack, mem_err data-bus response
//   wb_valid/we/rd/data         one-cycle completion to writeback
//   exc_valid/cause/tval        one-cycle precise exception
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic        lsu_is_store,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [4:0]  lsu_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   input  logic        mem_err,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        exc_valid,
   output logic [3:0]  exc_cause,
   output logic [31:0] exc_tval
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t state_q, state_d;

   // Latched request
   logic        is_store_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;      // byte offset actually used (after any force-align)
   logic [31:0] addr_q;     // original address, reported as tval
   logic [4:0]  rd_q;
   logic [CW-1:0] tmo_cnt;

   // Request decode
   logic        accept;
   logic        illegal;
   logic        misal_trap;
   logic [1:0]  off_in;
   logic [3:0]  strb_in;
   logic [31:0] wdata_in;

   assign lsu_ready = (state_q == IDLE);
   assign accept    = lsu_valid && lsu_ready;

   always_comb begin
      illegal = lsu_is_store ? (lsu_funct3 > 3'b010)
                             : (lsu_funct3 == 3'b011 || lsu_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      misal_trap = (lsu_funct3[1:0] == 2'b01 && lsu_addr[0]) ||
                   (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00);
`else
      misal_trap = 1'b0;
`endif
      // Force-aligned offset; identical to addr[1:0] whenever the access is aligned.
      case (lsu_funct3[1:0])
         2'b00:   off_in = lsu_addr[1:0];
         2'b01:   off_in = {lsu_addr[1], 1'b0};
         default: off_in = 2'b00;
      endcase
      case (lsu_funct3[1:0])
         2'b00:   begin strb_in = 4'b0001 << off_in; wdata_in = {4{lsu_wdata[7:0]}};  end
         2'b01:   begin strb_in = 4'b0011 << off_in; wdata_in = {2{lsu_wdata[15:0]}}; end
         default: begin strb_in = 4'b1111;           wdata_in = lsu_wdata;            end
      endcase
   end

   // Load extraction from the returned word
   logic [31:0] lane;
   logic [31:0] ld_data;
   always_comb begin
      lane = mem_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  ld_data = {{24{lane[7]}},  lane[7:0]};
         3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ld_data = {24'd0, lane[7:0]};
         3'b101:  ld_data = {16'd0, lane[15:0]};
         default: ld_data = lane;
      endcase
   end

   logic tmo_hit;
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (32'(tmo_cnt) == TIMEOUT_CYCLES - 1);

   // Next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = (illegal || misal_trap) ? DONE : BUS;
         BUS:  if (mem_err || mem_ack || tmo_hit) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_store_q <= 1'b0;
         funct3_q   <= 3'd0;
         off_q      <= 2'd0;
         addr_q     <= 32'd0;
         rd_q       <= 5'd0;
         tmo_cnt    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wstrb  <= 4'd0;
         mem_wdata  <= 32'd0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= 5'd0;
         wb_data    <= 32'd0;
         exc_valid  <= 1'b0;
         exc_cause  <= 4'd0;
         exc_tval   <= 32'd0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               is_store_q <= lsu_is_store;
               funct3_q   <= lsu_funct3;
               off_q      <= off_in;
               addr_q     <= lsu_addr;
               rd_q       <= lsu_rd;
               tmo_cnt    <= '0;
               if (illegal) begin
                  exc_valid <= 1'b1;
                  exc_cause <= 4'd2;
                  exc_tval  <= 32'd0;
               end else if (misal_trap) begin
                  exc_valid <= 1'b1;
                  exc_cause <= lsu_is_store ? 4'd6 : 4'd4;
                  exc_tval  <= lsu_addr;
               end else begin
                  mem_req   <= 1'b1;
                  mem_we    <= lsu_is_store;
                  mem_addr  <= {lsu_addr[31:2], 2'b00};
                  mem_wstrb <= lsu_is_store ? strb_in  : 4'd0;
                  mem_wdata <= lsu_is_store ? wdata_in : 32'd0;
               end
            end
            BUS: begin
               // Error has priority over a simultaneous ack.
               if (mem_err || (!mem_ack && tmo_hit)) begin
                  mem_req   <= 1'b0;
                  exc_valid <= 1'b1;
                  exc_cause <= is_store_q ? 4'd7 : 4'd5;
                  exc_tval  <= addr_q;
               end else if (mem_ack) begin
                  mem_req  <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_we    <= !is_store_q && (rd_q != 5'd0);
                  wb_rd    <= rd_q;
                  wb_data  <= is_store_q ? 32'd0 : ld_data;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DONE: begin
               mem_req   <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= 32'd0;
               mem_wstrb <= 4'd0;
               mem_wdata <= 32'd0;
               wb_valid  <= 1'b0;
               wb_we     <= 1'b0;
               wb_rd     <= 5'd0;
               wb_data   <= 32'd0;
               exc_valid <= 1'b0;
               exc_cause <= 4'd0;
               exc_tval  <= 32'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses compared against a byte-level behavioural model.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        lsu_valid = 1'b0;
   logic        lsu_ready;
   logic        lsu_is_store = 1'b0;
   logic [2:0]  lsu_funct3 = 3'd0;
   logic [31:0] lsu_addr = 32'd0;
   logic [31:0] lsu_wdata = 32'd0;
   logic [4:0]  lsu_rd = 5'd0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ack = 1'b0;
   logic        mem_err = 1'b0;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        exc_valid;
   logic [3:0]  exc_cause;
   logic [31:0] exc_tval;

   int checks = 0;
   int failures = 0;

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_is_store(lsu_is_store),
      .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rd(lsu_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_illegal(input bit st, input logic [2:0] f3);
      if (st) return !(f3 inside {3'd0, 3'd1, 3'd2});
      return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
   endfunction

   function automatic bit traps_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (a % nbytes(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   // Byte offset within the word after rounding down to the access size.
   function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
      return int'(a % 4) - int'(a % 4) % nbytes(f3);
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] word);
      longint v, mask;
      int n;
      n    = nbytes(f3);
      mask = (longint'(1) << (8 * n)) - 1;
      v    = (longint'(word) >> (8 * eff_off(f3, a))) & mask;
      if (!f3[2] && n < 4 && v >= (mask + 1) / 2) v = v - (mask + 1);
      return v[31:0];
   endfunction

   function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] s = 4'd0;
      for (int i = 0; i < nbytes(f3); i++) s[eff_off(f3, a) + i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      for (int j = 0; j < 4; j++) r[8*j +: 8] = d[8*(j % nbytes(f3)) +: 8];
      return r;
   endfunction

   // One complete access. resp_at = BUS cycle index where the response is driven;
   // at or beyond TMO the access times out instead.
   task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input int resp_at,
                         input bit ack, input bit err, input logic [31:0] rdata);
      bit imm_fault, fault, done, tmo;
      int cyc, req_cnt;
      logic [3:0] cause;
      logic [31:0] tval;
      @(negedge clk);
      chk("ready_before", 32'(lsu_ready), 32'd1);
      lsu_valid = 1'b1; lsu_is_store = st; lsu_funct3 = f3;
      lsu_addr = a; lsu_wdata = d; lsu_rd = rd;
      @(posedge clk);
      #1;
      // Garbage while busy must be ignored.
      lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_funct3 = 3'($urandom);
      imm_fault = is_illegal(st, f3) || traps_misaligned(f3, a);
      tmo = 1'b0;
      if (imm_fault) begin
         cause = is_illegal(st, f3) ? 4'd2 : (st ? 4'd6 : 4'd4);
         tval  = is_illegal(st, f3) ? 32'd0 : a;
         @(negedge clk);
         chk("imm_exc_valid", 32'(exc_valid), 32'd1);
         chk("imm_cause", 32'(exc_cause), 32'(cause));
         chk("imm_tval", exc_tval, tval);
         chk("imm_no_req", 32'(mem_req), 32'd0);
         chk("imm_no_wb", 32'(wb_valid), 32'd0);
      end else begin
         @(negedge clk);
         chk("req_addr", mem_addr, a & 32'hFFFF_FFFC);
         chk("req_we", 32'(mem_we), 32'(st));
         chk("req_strb", 32'(mem_wstrb), st ? 32'(model_strb(f3, a)) : 32'd0);
         if (st) chk("req_wdata", mem_wdata, model_wdata(f3, d));
         done = 1'b0; cyc = 0; req_cnt = 0;
         while (!done) begin
            if (mem_req) req_cnt++;
            if (cyc == resp_at) begin
               mem_ack = ack; mem_err = err; mem_rdata = rdata; done = 1'b1;
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
            cyc++;
            if (!done && cyc == TMO) begin done = 1'b1; tmo = 1'b1; end
            if (!done) @(negedge clk);
         end
         chk("req_cycles", 32'(req_cnt), tmo ? 32'(TMO) : 32'(resp_at + 1));
         fault = tmo || err;
         @(negedge clk);
         chk("done_req_low", 32'(mem_req), 32'd0);
         chk("done_wb_valid", 32'(wb_valid), 32'(!fault));
         chk("done_exc_valid", 32'(exc_valid), 32'(fault));
         if (fault) begin
            chk("fault_cause", 32'(exc_cause), st ? 32'd7 : 32'd5);
            chk("fault_tval", exc_tval, a);
         end else begin
            chk("wb_we", 32'(wb_we), 32'(!st && rd != 5'd0));
            chk("wb_rd", 32'(wb_rd), 32'(rd));
            chk("wb_data", wb_data, st ? 32'd0 : model_load(f3, a, rdata));
         end
      end
      @(negedge clk);
      chk("ready_after", 32'(lsu_ready), 32'd1);
      chk("pulse_gone", 32'(wb_valid | exc_valid), 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_ready", 32'(lsu_ready), 32'd1);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_wb", 32'(wb_valid), 32'd0);
      chk("rst_exc", 32'(exc_valid), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // LB sign-extended from byte 3; then rd=0 suppresses the register write
      access(1'b0, 3'b000, 32'h103, 32'd0, 5'd7, 0, 1'b1, 1'b0, 32'h80AA_BBCC);
      access(1'b0, 3'b000, 32'h103, 32'd0, 5'd0, 0, 1'b1, 1'b0, 32'h80AA_BBCC);
      // SH to the upper half-word
      access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 1, 1'b1, 1'b0, 32'd0);
      // Error beats simultaneous ack
      access(1'b0, 3'b010, 32'h300, 32'd0, 5'd4, 0, 1'b1, 1'b1, 32'h1111_2222);
      // Timeout on a store
      access(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd0, TMO + 3, 1'b1, 1'b0, 32'd0);
      // Misaligned LW: trap or force-align depending on build
      access(1'b0, 3'b010, 32'h302, 32'd0, 5'd5, 0, 1'b1, 1'b0, 32'hCAFE_F00D);
      // Illegal width codes
      access(1'b0, 3'b011, 32'h500, 32'd0, 5'd1, 0, 1'b1, 1'b0, 32'd0);
      access(1'b1, 3'b100, 32'h504, 32'h5, 5'd1, 0, 1'b1, 1'b0, 32'd0);

      // Stray ack while idle is ignored
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack_wb", 32'(wb_valid), 32'd0);
      chk("stray_ack_ready", 32'(lsu_ready), 32'd1);

      // Reset during BUS
      @(negedge clk);
      lsu_valid = 1'b1; lsu_is_store = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h80;
      @(posedge clk);
      #1 lsu_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_req_before", 32'(mem_req), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_req_async", 32'(mem_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mid_no_pulse", 32'(wb_valid | exc_valid | mem_req), 32'd0);
         chk("rst_mid_ready", 32'(lsu_ready), 32'd1);
      end
      access(1'b0, 3'b100, 32'h1, 32'd0, 5'd9, 0, 1'b1, 1'b0, 32'h0000_F000);

      // Randomized accesses
      for (int n = 0; n < 60; n++) begin
         bit st, er;
         logic [2:0] f3;
         int rat;
         st  = 1'($urandom);
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
         else if (st)                   f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         rat = $urandom_range(0, TMO + 1);
         er  = ($urandom_range(0, 7) == 0);
         access(st, f3, $urandom, $urandom, 5'($urandom), rat, !er, er, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
